// File: rtl/states_pkg.sv
// states_pkg: state encodings shared by the core scheduler, fetcher and LSUs
// Provides sched_state_t (core FSM), fetcher_state_t and lsu_state_t.
package states_pkg;
  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_REQUEST = 4'd3,
    S_WAIT    = 4'd4,
    S_EXECUTE = 4'd5,
    S_UPDATE  = 4'd6,
    S_DONE    = 4'd7,
    S_SELECT  = 4'd8
  } sched_state_t;
  typedef enum logic [2:0] {
    F_IDLE     = 3'd0,
    F_FETCHING = 3'd1,
    F_FETCHED  = 3'd2
  } fetcher_state_t;
  typedef enum logic [1:0] {
    L_IDLE       = 2'd0,
    L_REQUESTING = 2'd1,
    L_WAITING    = 2'd2,
    L_DONE       = 2'd3
  } lsu_state_t;
endpackage

// File: rtl/simt_scheduler_min_pc_select.sv
// min_pc_select: minimum PC over live lanes, via a binary reduction tree
// Ports: thread_pc_i/thread_done_i per lane in; min_pc_o, eq_mask_o (live lanes at min_pc_o),
// any_live_o (at least one lane not retired) out. Purely combinational.
module min_pc_select #(
  parameter int T        = 4,
  parameter int PC_WIDTH = 8
) (
  input  logic [T-1:0][PC_WIDTH-1:0] thread_pc_i,
  input  logic [T-1:0]               thread_done_i,
  output logic [PC_WIDTH-1:0]        min_pc_o,
  output logic [T-1:0]               eq_mask_o,
  output logic                       any_live_o
);
  // Heap layout: leaves at T-1..2T-2, node k combines children 2k+1 and 2k+2.
  logic [PC_WIDTH-1:0] node_pc [2*T-1];
  logic                node_live [2*T-1];
  always_comb begin
    for (int i = 0; i < T; i++) begin
      node_pc[T-1+i]   = thread_pc_i[i];
      node_live[T-1+i] = !thread_done_i[i];
    end
    for (int k = T-2; k >= 0; k--) begin
      node_live[k] = node_live[2*k+1] | node_live[2*k+2];
      node_pc[k]   = (node_live[2*k+1] && (!node_live[2*k+2] || node_pc[2*k+1] <= node_pc[2*k+2]))
                     ? node_pc[2*k+1] : node_pc[2*k+2];
    end
  end
  assign min_pc_o   = node_pc[0];
  assign any_live_o = node_live[0];
  always_comb
    for (int i = 0; i < T; i++) eq_mask_o[i] = !thread_done_i[i] && thread_pc_i[i] == min_pc_o;
endmodule

// File: rtl/simt_scheduler.sv
// simt_scheduler: per-core SIMT sequencer with per-thread PCs and min-PC reconvergence
// Ports: clk/reset (sync, active-high); start + thread_count launch a block; decoded_* and
// fetcher_state/lsu_state/next_pc come from the pipeline; current_pc, active_mask,
// core_state (sched_state_t) and done go back out.
module simt_scheduler
  import states_pkg::*;
#(
  parameter int THREADS_PER_BLOCK = 4,
  parameter int PC_WIDTH          = 8
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      start,
  input  logic [$clog2(THREADS_PER_BLOCK):0]        thread_count,
  input  logic                                      decoded_mem_read_enable,
  input  logic                                      decoded_mem_write_enable,
  input  logic                                      decoded_ret,
  input  logic [2:0]                                fetcher_state,
  input  logic [THREADS_PER_BLOCK-1:0][1:0]         lsu_state,
  input  logic [THREADS_PER_BLOCK-1:0][PC_WIDTH-1:0] next_pc,
  output logic [PC_WIDTH-1:0]                       current_pc,
  output logic [THREADS_PER_BLOCK-1:0]              active_mask,
  output logic [3:0]                                core_state,
  output logic                                      done
);
  localparam int T  = THREADS_PER_BLOCK;
  localparam int CW = $clog2(T) + 1;
  sched_state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]          pc_q, pc_d, min_pc;
  logic [T-1:0]                 mask_q, mask_d, tdone_q, tdone_d, eq_mask, busy;
  logic [T-1:0][PC_WIDTH-1:0]   tpc_q, tpc_d;
  logic                         done_q, done_d, any_live, mem_op;
  logic [CW-1:0]                tc;
  min_pc_select #(.T(T), .PC_WIDTH(PC_WIDTH)) u_min (
    .thread_pc_i   (tpc_q),
    .thread_done_i (tdone_q),
    .min_pc_o      (min_pc),
    .eq_mask_o     (eq_mask),
    .any_live_o    (any_live)
  );
  assign tc     = thread_count == '0 ? CW'(1) : thread_count;
  assign mem_op = decoded_mem_read_enable | decoded_mem_write_enable;
  always_comb
    for (int i = 0; i < T; i++) busy[i] = lsu_state[i] == L_REQUESTING || lsu_state[i] == L_WAITING;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    mask_d  = mask_q;
    done_d  = done_q;
    tpc_d   = tpc_q;
    tdone_d = tdone_q;
    case (state_q)
      S_IDLE: if (start) begin
        tpc_d = '0;
        for (int i = 0; i < T; i++) tdone_d[i] = CW'(i) >= tc;
        state_d = S_SELECT;
      end
      S_SELECT: begin
        done_d  = !any_live;
        pc_d    = any_live ? min_pc : pc_q;
        mask_d  = any_live ? eq_mask : mask_q;
        state_d = any_live ? S_FETCH : S_DONE;
      end
      S_FETCH:   state_d = fetcher_state == F_FETCHED ? S_DECODE : S_FETCH;
      S_DECODE:  state_d = S_REQUEST;
      S_REQUEST: state_d = S_WAIT;
      // Only lanes that issued the access can hold the core back.
      S_WAIT:    state_d = (mem_op && |(mask_q & busy)) ? S_WAIT : S_EXECUTE;
      S_EXECUTE: state_d = S_UPDATE;
      S_UPDATE: begin
        for (int i = 0; i < T; i++)
          if (mask_q[i]) begin
            if (decoded_ret) tdone_d[i] = 1'b1;
            else tpc_d[i] = next_pc[i];
          end
        state_d = S_SELECT;
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      mask_q  <= '0;
      done_q  <= 1'b0;
      tpc_q   <= '0;
      tdone_q <= '1;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      mask_q  <= mask_d;
      done_q  <= done_d;
      tpc_q   <= tpc_d;
      tdone_q <= tdone_d;
    end
  end
  assign current_pc  = pc_q;
  assign active_mask = mask_q;
  assign core_state  = state_q;
  assign done        = done_q;
endmodule
